sim_halt_monitor: RTL and testbench
===================================

// Module: sim_halt_monitor
// PURPOSE
//   Parametrised end-of-simulation detector for the sim harness. Watches the PU state and N I/O
//   activity flags, declares the machine stopped after a programmable run of quiet cycles, adds a
//   cycle watchdog with timeout, and reports stop cause, cycle count and restart count.
//   Sits in sim_top beside sim_input/sim_output; the testbench polls machine_is_stop / sim_done.
// PARAMETERS
//   STATE_W      3   width of pu_state
//   IDLE_STATE   0   pu_state value meaning "PU stopped"
//   NUM_CH       2   number of I/O activity flags (input, output, ...)
//   QUIET_W      8   width of quiet counter
//   QUIET_CYCLES 255 consecutive quiet cycles needed to declare stop; legal range 1..2^QUIET_W-1
//   STICKY       0   1: stop latched until clear/reset; 0: stop drops as soon as activity resumes
//   WDOG_W       32  width of cycle_count
//   WDOG_LIMIT   0   cycle_count value that triggers timeout; 0 disables the watchdog
//   RST_W        16  width of restart_count
// PORTS
//   clk             in   1        clock
//   resetn          in   1        synchronous reset, active low
//   clear           in   1        synchronous re-arm: state->RUN, counters and flags cleared
//   pu_state        in   STATE_W  PU state from soc_top
//   io_active       in   NUM_CH   per-channel activity flags (pnl_input_active, pnl_output_active, ...)
//   machine_is_stop out  1        quiet-stop detected
//   machine_timeout out  1        watchdog fired (always sticky)
//   sim_done        out  1        machine_is_stop | machine_timeout
//   stop_cause      out  2        0 none, 1 quiet stop, 2 timeout
//   cycle_count     out  WDOG_W   cycles since reset/clear, saturating at all-ones
//   restart_count   out  RST_W    number of idle->non-idle pu_state transitions, saturating
// BEHAVIOUR
//   - Reset/clear: state RUN, all counters 0, all outputs 0; clear has the same effect as resetn.
//   - quiet = (pu_state == IDLE_STATE) && !(|io_active), sampled each rising edge.
//   - Registered 4-state FSM, outputs decoded from state (no combinational path from inputs):
//     RUN:     quiet -> QUIET with quiet_cnt <= 1 (-> STOP directly if QUIET_CYCLES == 1).
//     QUIET:   quiet -> quiet_cnt+1; the edge where it reaches QUIET_CYCLES -> STOP;
//              !quiet -> RUN, quiet_cnt <= 0.
//     STOP:    STICKY=0: !quiet -> RUN, quiet_cnt <= 0. STICKY=1: hold until clear/reset.
//     TIMEOUT: terminal until clear/reset.
//   - machine_is_stop = 1 in STOP only; asserts the cycle after the QUIET_CYCLES-th consecutive quiet edge.
//   - Watchdog: cycle_count increments every edge out of reset, saturating. If WDOG_LIMIT != 0 and
//     the incremented value equals WDOG_LIMIT while state != STOP -> TIMEOUT next cycle.
//     In STOP the watchdog does not fire; with STICKY=0 and a resume, it can fire later.
//   - Simultaneous: quiet-stop completion and watchdog limit on the same edge -> STOP wins.
//   - restart_count: +1 on each edge where previous pu_state == IDLE_STATE and current != IDLE_STATE;
//     the first sampled cycle after reset/clear does not count; saturates at all-ones.
//   - stop_cause: 1 in STOP, 2 in TIMEOUT, else 0.
//   - Width rule: quiet_cnt saturates at QUIET_CYCLES and never wraps.
// STRUCTURE
//   - Shared package sim_pkg: FSM state encoding (S_RUN, S_QUIET, S_STOP, S_TIMEOUT) and stop_cause codes.
//   - One natural sub-module: sim_sat_counter #(W) (inc, clr, saturating), instantiated three times
//     (quiet, cycle, restart). FSM and edge detect stay in this module.
//   - sim_top instantiates with NUM_CH=2, QUIET_CYCLES=255, STICKY=0, WDOG_LIMIT=0; the
//     io_active[1:0] connection is {pnl_output_active, pnl_input_active}.
// TESTING
//   1. QUIET_CYCLES=4: pu_state=0, io_active=0 from reset -> machine_is_stop=1 on cycle 5, stop_cause=1, sim_done=1.
//   2. QUIET_CYCLES=4: idle 3 cycles, io_active[1]=1 for 1 cycle, idle again -> stop only 4 cycles after activity drops.
//   3. STICKY=0, in STOP: pu_state=3 for 1 cycle -> stop drops next cycle, restart_count=1.
//      STICKY=1, same stimulus -> stop stays 1.
//   4. WDOG_LIMIT=100, pu_state never idle -> machine_timeout=1 and stop_cause=2 from cycle 101 onward; clear -> all 0.
//   5. QUIET_CYCLES=4, WDOG_LIMIT=4, idle from reset -> STOP wins and machine_timeout stays 0.
//   6. resetn low for 1 cycle while in QUIET with cnt=3 -> all outputs and counters 0; re-detect takes the full 4 cycles.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared definitions for the simulation end-of-run monitor: FSM state
// encoding, stop cause codes and the state-to-cause decode.
package sim_pkg;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_QUIET   = 2'd1,
        S_STOP    = 2'd2,
        S_TIMEOUT = 2'd3
    } sim_state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_QUIET   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // The reported stop cause is purely a function of the registered state,
    // so it can never glitch with the inputs.
    function automatic logic [1:0] cause_of(input sim_state_t s);
        logic [1:0] c;
        c = CAUSE_NONE;
        if (s == S_STOP)    c = CAUSE_QUIET;
        if (s == S_TIMEOUT) c = CAUSE_TIMEOUT;
        return c;
    endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// Saturating up-counter with synchronous clear. Counts up on inc and holds
// at MAX instead of wrapping; clr (or reset) takes priority over inc.
module sim_sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins, otherwise step up until the ceiling is reached.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sim_halt_monitor.sv
// End-of-simulation detector: declares the machine stopped after a run of
// quiet cycles (PU idle and no I/O activity), runs a cycle watchdog, and
// counts how often the PU restarts from idle.
module sim_halt_monitor
    import sim_pkg::*;
#(
    parameter int STATE_W      = 3,
    parameter int IDLE_STATE   = 0,
    parameter int NUM_CH       = 2,
    parameter int QUIET_W      = 8,
    parameter int QUIET_CYCLES = 255,
    parameter bit STICKY       = 1'b0,
    parameter int WDOG_W       = 32,
    parameter longint unsigned WDOG_LIMIT = 0,
    parameter int RST_W        = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic [STATE_W-1:0] pu_state,
    input  logic [NUM_CH-1:0]  io_active,
    output logic               machine_is_stop,
    output logic               machine_timeout,
    output logic               sim_done,
    output logic [1:0]         stop_cause,
    output logic [WDOG_W-1:0]  cycle_count,
    output logic [RST_W-1:0]   restart_count
);

    localparam logic [QUIET_W-1:0] QUIET_MAX = QUIET_W'(QUIET_CYCLES);
    localparam logic [WDOG_W-1:0]  WDOG_LIM  = WDOG_W'(WDOG_LIMIT);
    localparam logic [STATE_W-1:0] IDLE_VAL  = STATE_W'(IDLE_STATE);

    sim_state_t         state;
    sim_state_t         state_next;
    logic [QUIET_W-1:0] quiet_cnt;
    logic               quiet_inc;
    logic               quiet_clr;
    logic               quiet;
    logic               quiet_done;
    logic               cur_idle;
    logic               prev_idle;
    logic               prev_valid;
    logic               restart_inc;
    logic [WDOG_W-1:0]  cycle_inc;
    logic               wdog_hit;

    assign cur_idle   = (pu_state == IDLE_VAL);
    assign quiet      = cur_idle && !(|io_active);
    // This edge is the QUIET_CYCLES-th consecutive quiet one.
    assign quiet_done = quiet && ((quiet_cnt + QUIET_W'(1)) == QUIET_MAX);

    // The watchdog compares against the value cycle_count takes on this edge.
    assign cycle_inc  = (cycle_count == '1) ? cycle_count : cycle_count + WDOG_W'(1);
    assign wdog_hit   = (WDOG_LIM != '0) && (cycle_inc == WDOG_LIM);

    assign restart_inc = prev_valid && prev_idle && !cur_idle;

    // Next-state logic; a quiet-stop completing on the watchdog edge wins.
    always_comb begin
        state_next = state;
        quiet_inc  = 1'b0;
        quiet_clr  = 1'b0;
        case (state)
            S_RUN: begin
                if (quiet) begin
                    quiet_inc  = 1'b1;
                    state_next = quiet_done ? S_STOP : S_QUIET;
                end
            end
            S_QUIET: begin
                if (quiet) begin
                    quiet_inc  = 1'b1;
                    if (quiet_done) state_next = S_STOP;
                end else begin
                    quiet_clr  = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_STOP: begin
                if (!STICKY && !quiet) begin
                    quiet_clr  = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_TIMEOUT: begin
                state_next = S_TIMEOUT;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
        if (wdog_hit && (state == S_RUN || state == S_QUIET) && state_next != S_STOP) begin
            state_next = S_TIMEOUT;
        end
    end

    // State register; clear re-arms exactly like reset.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Remember the previous pu_state idleness; the first sample after reset has no history.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            prev_idle  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            prev_idle  <= cur_idle;
            prev_valid <= 1'b1;
        end
    end

    sim_sat_counter #(.W(QUIET_W), .MAX(QUIET_MAX)) u_quiet_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clear || quiet_clr),
        .inc    (quiet_inc),
        .count  (quiet_cnt)
    );

    sim_sat_counter #(.W(WDOG_W)) u_cycle_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clear),
        .inc    (1'b1),
        .count  (cycle_count)
    );

    sim_sat_counter #(.W(RST_W)) u_restart_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clear),
        .inc    (restart_inc),
        .count  (restart_count)
    );

    assign machine_is_stop = (state == S_STOP);
    assign machine_timeout = (state == S_TIMEOUT);
    assign sim_done        = machine_is_stop || machine_timeout;
    assign stop_cause      = cause_of(state);

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Directed bench for sim_halt_monitor: several parameterisations share one
// clock; a/b/d/e share inputs, c has its own for the long watchdog run.
module tb_sim_halt_monitor;

    logic        clk = 1'b0;
    logic        resetn, clear, resetn_c, clear_c;
    logic [2:0]  pu_state, pu_state_c;
    logic [1:0]  io_active, io_active_c;

    logic        a_stop, a_tmo, a_done;  logic [1:0] a_cause; logic [31:0] a_cyc; logic [15:0] a_rst;
    logic        b_stop, b_tmo, b_done;  logic [1:0] b_cause; logic [31:0] b_cyc; logic [15:0] b_rst;
    logic        c_stop, c_tmo, c_done;  logic [1:0] c_cause; logic [31:0] c_cyc; logic [15:0] c_rst;
    logic        d_stop, d_tmo, d_done;  logic [1:0] d_cause; logic [31:0] d_cyc; logic [15:0] d_rst;
    logic        e_stop, e_tmo, e_done;  logic [1:0] e_cause; logic [31:0] e_cyc; logic [15:0] e_rst;

    int check_count = 0;
    int fail_count  = 0;

    always #5 clk = ~clk;

    sim_halt_monitor #(.QUIET_CYCLES(4), .STICKY(1'b0), .WDOG_LIMIT(0)) u_a (
        .clk(clk), .resetn(resetn), .clear(clear), .pu_state(pu_state), .io_active(io_active),
        .machine_is_stop(a_stop), .machine_timeout(a_tmo), .sim_done(a_done),
        .stop_cause(a_cause), .cycle_count(a_cyc), .restart_count(a_rst));

    sim_halt_monitor #(.QUIET_CYCLES(4), .STICKY(1'b1), .WDOG_LIMIT(0)) u_b (
        .clk(clk), .resetn(resetn), .clear(clear), .pu_state(pu_state), .io_active(io_active),
        .machine_is_stop(b_stop), .machine_timeout(b_tmo), .sim_done(b_done),
        .stop_cause(b_cause), .cycle_count(b_cyc), .restart_count(b_rst));

    sim_halt_monitor #(.QUIET_CYCLES(4), .STICKY(1'b0), .WDOG_LIMIT(100)) u_c (
        .clk(clk), .resetn(resetn_c), .clear(clear_c), .pu_state(pu_state_c), .io_active(io_active_c),
        .machine_is_stop(c_stop), .machine_timeout(c_tmo), .sim_done(c_done),
        .stop_cause(c_cause), .cycle_count(c_cyc), .restart_count(c_rst));

    sim_halt_monitor #(.QUIET_CYCLES(4), .STICKY(1'b0), .WDOG_LIMIT(4)) u_d (
        .clk(clk), .resetn(resetn), .clear(clear), .pu_state(pu_state), .io_active(io_active),
        .machine_is_stop(d_stop), .machine_timeout(d_tmo), .sim_done(d_done),
        .stop_cause(d_cause), .cycle_count(d_cyc), .restart_count(d_rst));

    sim_halt_monitor #(.QUIET_CYCLES(1), .STICKY(1'b0), .WDOG_LIMIT(0)) u_e (
        .clk(clk), .resetn(resetn), .clear(clear), .pu_state(pu_state), .io_active(io_active),
        .machine_is_stop(e_stop), .machine_timeout(e_tmo), .sim_done(e_done),
        .stop_cause(e_cause), .cycle_count(e_cyc), .restart_count(e_rst));

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the shared inputs and run n edges.
    task automatic applyStimulus(input logic [2:0] ps, input logic [1:0] act, input int n);
        pu_state  = ps;
        io_active = act;
        tick(n);
    endtask

    // One comparison: count it, and report when it does not hold.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        resetn = 1'b0; clear = 1'b0; resetn_c = 1'b0; clear_c = 1'b0;
        pu_state = 3'd0; io_active = 2'b00; pu_state_c = 3'd3; io_active_c = 2'b00;
        tick(2);

        $display("[TB] reset state");
        checkOutput("rst_stop",    64'(a_stop),  64'd0);
        checkOutput("rst_timeout", 64'(a_tmo),   64'd0);
        checkOutput("rst_done",    64'(a_done),  64'd0);
        checkOutput("rst_cause",   64'(a_cause), 64'd0);
        checkOutput("rst_cycle",   64'(a_cyc),   64'd0);
        checkOutput("rst_restart", 64'(a_rst),   64'd0);
        checkOutput("rst_c_cycle", 64'(c_cyc),   64'd0);

        $display("[TB] quiet stop from reset");
        resetn = 1'b1;
        applyStimulus(3'd0, 2'b00, 1);
        checkOutput("qc1_stop_edge1",  64'(e_stop),  64'd1);
        checkOutput("qc1_cause_edge1", 64'(e_cause), 64'd1);
        checkOutput("a_stop_edge1",    64'(a_stop),  64'd0);
        applyStimulus(3'd0, 2'b00, 2);
        checkOutput("a_stop_edge3",    64'(a_stop),  64'd0);
        checkOutput("a_cycle_edge3",   64'(a_cyc),   64'd3);
        applyStimulus(3'd0, 2'b00, 1);
        checkOutput("a_stop_edge4",    64'(a_stop),  64'd1);
        checkOutput("a_cause_edge4",   64'(a_cause), 64'd1);
        checkOutput("a_done_edge4",    64'(a_done),  64'd1);
        checkOutput("d_stop_wins",     64'(d_stop),  64'd1);
        checkOutput("d_no_timeout",    64'(d_tmo),   64'd0);
        checkOutput("d_cause_quiet",   64'(d_cause), 64'd1);
        checkOutput("b_stop_edge4",    64'(b_stop),  64'd1);

        $display("[TB] resume from stop");
        applyStimulus(3'd3, 2'b00, 1);
        checkOutput("a_stop_resume",   64'(a_stop),  64'd0);
        checkOutput("a_cause_resume",  64'(a_cause), 64'd0);
        checkOutput("a_restart_1",     64'(a_rst),   64'd1);
        checkOutput("b_sticky_stop",   64'(b_stop),  64'd1);
        checkOutput("b_restart_1",     64'(b_rst),   64'd1);
        checkOutput("e_stop_resume",   64'(e_stop),  64'd0);
        applyStimulus(3'd0, 2'b00, 1);
        checkOutput("e_restop",        64'(e_stop),  64'd1);
        checkOutput("a_stop_requiet",  64'(a_stop),  64'd0);
        checkOutput("d_timeout_later", 64'(d_tmo),   64'd0);

        $display("[TB] clear re-arms");
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checkOutput("clr_a_cycle",     64'(a_cyc),   64'd0);
        checkOutput("clr_a_restart",   64'(a_rst),   64'd0);
        checkOutput("clr_b_stop",      64'(b_stop),  64'd0);
        checkOutput("clr_b_cause",     64'(b_cause), 64'd0);

        $display("[TB] activity restarts the quiet run");
        applyStimulus(3'd0, 2'b00, 3);
        applyStimulus(3'd0, 2'b10, 1);
        checkOutput("act_a_stop",      64'(a_stop),  64'd0);
        checkOutput("act_e_stop",      64'(e_stop),  64'd0);
        applyStimulus(3'd0, 2'b00, 3);
        checkOutput("act_a_stop_3",    64'(a_stop),  64'd0);
        applyStimulus(3'd0, 2'b00, 1);
        checkOutput("act_a_stop_4",    64'(a_stop),  64'd1);
        checkOutput("act_a_restart",   64'(a_rst),   64'd0);

        $display("[TB] reset in the middle of a quiet run");
        applyStimulus(3'd3, 2'b00, 1);
        checkOutput("mid_a_restart",   64'(a_rst),   64'd1);
        applyStimulus(3'd0, 2'b00, 3);
        checkOutput("mid_a_stop",      64'(a_stop),  64'd0);
        resetn = 1'b0;
        tick(1);
        checkOutput("mid_rst_stop",    64'(a_stop),  64'd0);
        checkOutput("mid_rst_done",    64'(a_done),  64'd0);
        checkOutput("mid_rst_cause",   64'(a_cause), 64'd0);
        checkOutput("mid_rst_cycle",   64'(a_cyc),   64'd0);
        checkOutput("mid_rst_restart", 64'(a_rst),   64'd0);
        resetn = 1'b1;
        applyStimulus(3'd0, 2'b00, 3);
        checkOutput("redetect_stop_3", 64'(a_stop),  64'd0);
        checkOutput("redetect_cyc_3",  64'(a_cyc),   64'd3);
        applyStimulus(3'd0, 2'b00, 1);
        checkOutput("redetect_stop_4", 64'(a_stop),  64'd1);
        checkOutput("redetect_d_stop", 64'(d_stop),  64'd1);
        checkOutput("redetect_d_tmo",  64'(d_tmo),   64'd0);

        $display("[TB] watchdog timeout");
        resetn_c = 1'b1;
        tick(99);
        checkOutput("wd_tmo_99",       64'(c_tmo),   64'd0);
        checkOutput("wd_cause_99",     64'(c_cause), 64'd0);
        checkOutput("wd_cycle_99",     64'(c_cyc),   64'd99);
        tick(1);
        checkOutput("wd_tmo_100",      64'(c_tmo),   64'd1);
        checkOutput("wd_cause_100",    64'(c_cause), 64'd2);
        checkOutput("wd_done_100",     64'(c_done),  64'd1);
        checkOutput("wd_stop_100",     64'(c_stop),  64'd0);
        tick(2);
        checkOutput("wd_tmo_sticky",   64'(c_tmo),   64'd1);
        checkOutput("wd_cycle_102",    64'(c_cyc),   64'd102);
        checkOutput("wd_restart",      64'(c_rst),   64'd0);
        clear_c = 1'b1;
        tick(1);
        clear_c = 1'b0;
        checkOutput("wd_clr_tmo",      64'(c_tmo),   64'd0);
        checkOutput("wd_clr_cause",    64'(c_cause), 64'd0);
        checkOutput("wd_clr_done",     64'(c_done),  64'd0);
        checkOutput("wd_clr_cycle",    64'(c_cyc),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
